// File: rtl/bcd_scan_display_pkg.sv
// Shared types and constants for the multiplexed 3-digit BCD display.
package bcd_display_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } scan_state_e;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Digits 10..15 are not valid BCD and show a dash
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
        SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
    };

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit inputs and display pins of the scanned BCD display.
interface bcd_scan_display_if;

    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       load;
    logic       blank_en;
    logic [6:0] seg_n;
    logic [2:0] dig_n;
    logic       scan_tick;

    // Side that supplies digits and watches the display pins
    modport master (
        output hundreds, tens, ones, load, blank_en,
        input  seg_n, dig_n, scan_tick
    );

    // The display controller itself
    modport slave (
        input  hundreds, tens, ones, load, blank_en,
        output seg_n, dig_n, scan_tick
    );

endinterface

// File: rtl/bcd_scan_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/bcd_scan_display.sv
// Latches a 3-digit BCD value and scans it onto a common-anode display,
// with a blank guard interval between digits and leading-zero suppression.
module bcd_scan_display
    import bcd_display_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [7:0]  GUARD_CYCLES = 8'd4,
    parameter int          CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    bcd_scan_display_if.slave  bus
);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV) - CNT_W'(1);
    // Wraps when GUARD_CYCLES is 0, but GUARD is never entered in that case
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES) - CNT_W'(1);
    localparam bit               HAS_GUARD  = (GUARD_CYCLES != 8'd0);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       hund_q, tens_q, ones_q;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       dig_q, dig_d;
    logic             tick_q, tick_d;
    logic             advance;
    logic             wrap;
    logic [3:0]       digit_mux;
    logic [6:0]       seg_dec;
    logic             blank_dig;

    // State, counters, shadow digits and registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            idx_q   <= DIG_ONES;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            seg_q   <= SEG_BLANK;
            dig_q   <= 3'b111;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
            if (bus.load) begin
                hund_q <= bus.hundreds;
                tens_q <= bus.tens;
                ones_q <= bus.ones;
            end
        end
    end

    // Dwell/guard sequencing and digit index rotation ones -> tens -> hundreds
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        advance = 1'b0;
        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (HAS_GUARD) begin
                        state_d = GUARD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        endcase

        idx_d = idx_q;
        wrap  = 1'b0;
        if (advance) begin
            case (idx_q)
                DIG_ONES: idx_d = DIG_TENS;
                DIG_TENS: idx_d = DIG_HUNDREDS;
                default: begin
                    idx_d = DIG_ONES;
                    wrap  = 1'b1;
                end
            endcase
        end
    end

    // Select the shadow digit for the current index and decide blanking
    always_comb begin
        case (idx_q)
            DIG_ONES: digit_mux = ones_q;
            DIG_TENS: digit_mux = tens_q;
            default:  digit_mux = hund_q;
        endcase
        blank_dig = bus.blank_en &&
                    (((idx_q == DIG_HUNDREDS) && (hund_q == 4'd0)) ||
                     ((idx_q == DIG_TENS) && (hund_q == 4'd0) && (tens_q == 4'd0)));
    end

    seg7_decode u_decode (
        .digit_i (digit_mux),
        .seg_n_o (seg_dec)
    );

    // Next display pin values: everything dark during GUARD
    always_comb begin
        seg_d  = SEG_BLANK;
        dig_d  = 3'b111;
        tick_d = wrap;
        if (state_q == SHOW) begin
            dig_d = ~(3'b001 << idx_q);
            seg_d = blank_dig ? SEG_BLANK : seg_dec;
        end
    end

    assign bus.seg_n     = seg_q;
    assign bus.dig_n     = dig_q;
    assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench: two display instances (with and without guard) driven
// by the same digit stream, checked cycle by cycle against a scan model.
module tb_bcd_scan_display;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] dig;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] h_s = 4'd0;
    logic [3:0] t_s = 4'd0;
    logic [3:0] o_s = 4'd0;
    logic       ld_s = 1'b0;
    logic       bl_s = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_a = -1;
    int   last_b = -1;
    int   pos_a = 0;
    int   pos_b = 0;
    logic [3:0] sh_h = 4'd0;
    logic [3:0] sh_t = 4'd0;
    logic [3:0] sh_o = 4'd0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;

    bcd_scan_display_if ifa ();
    bcd_scan_display_if ifb ();

    assign ifa.hundreds = h_s;
    assign ifa.tens     = t_s;
    assign ifa.ones     = o_s;
    assign ifa.load     = ld_s;
    assign ifa.blank_en = bl_s;
    assign ifb.hundreds = h_s;
    assign ifb.tens     = t_s;
    assign ifb.ones     = o_s;
    assign ifb.load     = ld_s;
    assign ifb.blank_en = bl_s;

    bcd_scan_display #(.SCAN_DIV(16'd4), .GUARD_CYCLES(8'd2), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    bcd_scan_display #(.SCAN_DIV(16'd1), .GUARD_CYCLES(8'd0), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // pos = cycle position within the full scan period of 3*(s+g)
    function automatic exp_t model_out(input int s, input int g, input int pos,
                                       input logic [3:0] h, input logic [3:0] t,
                                       input logic [3:0] o, input logic bl);
        exp_t e;
        int ph;
        int w;
        logic [3:0] d;
        logic blk;
        ph = pos / (s + g);
        w  = pos % (s + g);
        e.tick = (pos == 3 * (s + g) - 1);
        e.seg  = 7'h7F;
        e.dig  = 3'b111;
        if (w < s) begin
            case (ph)
                0: d = o;
                1: d = t;
                default: d = h;
            endcase
            blk = bl && (((ph == 2) && (h == 4'd0)) || ((ph == 1) && (h == 4'd0) && (t == 4'd0)));
            e.dig[ph] = 1'b0;
            e.seg = blk ? 7'h7F : ref_seg(d);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pos_a = 0;
            pos_b = 0;
            sh_h  = 4'd0;
            sh_t  = 4'd0;
            sh_o  = 4'd0;
        end else begin
            qa.push_back(model_out(4, 2, pos_a, sh_h, sh_t, sh_o, bl_s));
            qb.push_back(model_out(1, 0, pos_b, sh_h, sh_t, sh_o, bl_s));
            pos_a = (pos_a + 1) % 18;
            pos_b = (pos_b + 1) % 3;
            if (ld_s) begin
                sh_h = h_s;
                sh_t = t_s;
                sh_o = o_s;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            check_val("A.seg_n", ifa.seg_n, ea.seg);
            check_val("A.dig_n", ifa.dig_n, ea.dig);
            check_val("A.scan_tick", ifa.scan_tick, ea.tick);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            check_val("B.seg_n", ifb.seg_n, eb.seg);
            check_val("B.dig_n", ifb.dig_n, eb.dig);
            check_val("B.scan_tick", ifb.scan_tick, eb.tick);
        end
        if (rst) begin
            last_a = -1;
            last_b = -1;
        end else begin
            if (ifa.scan_tick === 1'b1) begin
                if (last_a >= 0) check_val("A.tick_period", cyc - last_a, 18);
                last_a = cyc;
            end
            if (ifb.scan_tick === 1'b1) begin
                if (last_b >= 0) check_val("B.tick_period", cyc - last_b, 3);
                last_b = cyc;
            end
        end
    end

    task automatic load_val(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        #1;
        h_s  = h;
        t_s  = t;
        o_s  = o;
        ld_s = 1'b1;
        @(negedge clk);
        #1;
        ld_s = 1'b0;
    endtask

    task automatic wait_dig(input logic [2:0] dig, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((ifa.dig_n !== dig) && (k < 60));
        if (ifa.dig_n !== dig) check_val({tag, ".timeout"}, ifa.dig_n, dig);
    endtask

    task automatic check_reset_pins(input string tag);
        check_val({tag, ".A.seg_n"}, ifa.seg_n, 7'h7F);
        check_val({tag, ".A.dig_n"}, ifa.dig_n, 3'b111);
        check_val({tag, ".A.tick"}, ifa.scan_tick, 1'b0);
        check_val({tag, ".B.seg_n"}, ifb.seg_n, 7'h7F);
        check_val({tag, ".B.dig_n"}, ifb.dig_n, 3'b111);
        check_val({tag, ".B.tick"}, ifb.scan_tick, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_pins("por");
        #1 rst = 1'b0;

        load_val(4'd1, 4'd2, 4'd3);
        wait_dig(3'b110, "ones123");
        check_val("ones123", ifa.seg_n, 7'b0110000);
        wait_dig(3'b101, "tens123");
        check_val("tens123", ifa.seg_n, 7'b0100100);
        wait_dig(3'b011, "hund123");
        check_val("hund123", ifa.seg_n, 7'b1111001);

        bl_s = 1'b1;
        load_val(4'd0, 4'd0, 4'd7);
        wait_dig(3'b110, "ones007");
        check_val("ones007", ifa.seg_n, 7'b1111000);
        wait_dig(3'b101, "tens007blk");
        check_val("tens007blk", ifa.seg_n, 7'b1111111);
        wait_dig(3'b011, "hund007blk");
        check_val("hund007blk", ifa.seg_n, 7'b1111111);
        #1 bl_s = 1'b0;
        wait_dig(3'b101, "tens007");
        check_val("tens007", ifa.seg_n, 7'b1000000);
        wait_dig(3'b011, "hund007");
        check_val("hund007", ifa.seg_n, 7'b1000000);

        #1 bl_s = 1'b1;
        load_val(4'd0, 4'd10, 4'd5);
        wait_dig(3'b110, "ones0A5");
        check_val("ones0A5", ifa.seg_n, 7'b0010010);
        wait_dig(3'b101, "tens0A5");
        check_val("tens0A5", ifa.seg_n, 7'b0111111);
        wait_dig(3'b011, "hund0A5blk");
        check_val("hund0A5blk", ifa.seg_n, 7'b1111111);
        #1 bl_s = 1'b0;
        wait_dig(3'b011, "hund0A5");
        check_val("hund0A5", ifa.seg_n, 7'b1000000);

        // inputs move without load: display must hold 0A5
        #1;
        h_s = 4'd4;
        t_s = 4'd4;
        o_s = 4'd4;
        repeat (20) @(negedge clk);
        wait_dig(3'b111, "guard_noload");
        wait_dig(3'b110, "ones_noload");
        check_val("ones_noload", ifa.seg_n, 7'b0010010);

        // load 999 during the first cycle of the ones dwell
        #1;
        h_s  = 4'd9;
        t_s  = 4'd9;
        o_s  = 4'd9;
        ld_s = 1'b1;
        @(negedge clk);
        check_val("mid_old_seg", ifa.seg_n, 7'b0010010);
        check_val("mid_old_dig", ifa.dig_n, 3'b110);
        #1 ld_s = 1'b0;
        @(negedge clk);
        check_val("mid_new_seg", ifa.seg_n, 7'b0010000);
        check_val("mid_new_dig", ifa.dig_n, 3'b110);

        // load held high: shadow tracks the inputs every cycle
        ld_s = 1'b1;
        repeat (40) begin
            @(negedge clk);
            #1;
            h_s  = 4'($urandom_range(0, 15));
            t_s  = 4'($urandom_range(0, 15));
            o_s  = 4'($urandom_range(0, 15));
            bl_s = 1'($urandom_range(0, 1));
        end
        ld_s = 1'b0;

        // asynchronous reset in the middle of a guard interval
        wait_dig(3'b111, "guard_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        check_reset_pins("async");
        repeat (2) @(negedge clk);
        check_reset_pins("held");
        #1 rst = 1'b0;

        repeat (60) begin
            @(negedge clk);
            #1;
            h_s  = 4'($urandom_range(0, 15));
            t_s  = 4'($urandom_range(0, 15));
            o_s  = 4'($urandom_range(0, 15));
            ld_s = ($urandom_range(0, 3) == 0);
            bl_s = 1'($urandom_range(0, 1));
        end
        ld_s = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the binary-to-BCD converter's hundreds/tens/ones digits.
- Latches a 3-digit BCD value on a load strobe and time-multiplexes it onto a 3-digit common-anode seven-segment display.
- Provides a programmable per-digit dwell time, an anti-ghosting guard interval, optional leading-zero blanking, and a dash for invalid digits (>9).
- Sits between the BCD converter and the board's HEX display pins; shows frame/iteration counts for the Julia set renderer.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles each digit is lit (must be >=1).
- GUARD_CYCLES, 8'd4, all-digits-off cycles between digits (0 = no guard state).
- CNT_W, 16, width of the dwell/guard counter (must hold SCAN_DIV-1 and GUARD_CYCLES-1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- hundreds  input  4  BCD hundreds digit
- tens  input  4  BCD tens digit
- ones  input  4  BCD ones digit
- load  input  1  capture hundreds/tens/ones into the shadow registers on this clock edge
- blank_en  input  1  enable leading-zero suppression
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- dig_n  output  3  digit enables {hundreds,tens,ones}, active-low
- scan_tick  output  1  one-cycle pulse when the scan wraps from hundreds back to ones

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset); all state clears immediately on reset assertion, independent of clk.
- Reset values:
  - seg_n = 7'b1111111, dig_n = 3'b111, scan_tick = 0
  - shadow digits = 0, digit index = 0 (ones), counter = 0, state = SHOW
- Load:
  - When load = 1 at a rising edge, the shadow registers take the inputs.
  - The new value is used from the next cycle's output computation.
  - load is level-sampled each cycle; holding it high continuously tracks the inputs.
- State machine:
  - SHOW: counter counts 0..SCAN_DIV-1.
    - At SCAN_DIV-1 with GUARD_CYCLES > 0: counter = 0, go to GUARD.
    - At SCAN_DIV-1 with GUARD_CYCLES = 0: counter = 0, advance index, stay in SHOW.
  - GUARD: counter counts 0..GUARD_CYCLES-1; at the terminal count, counter = 0, advance index, go to SHOW.
- Index sequence is 0 (ones) -> 1 (tens) -> 2 (hundreds) -> 0.
  - scan_tick pulses for the single cycle on which the index advance 2 -> 0 is registered.
- Outputs are registered, so dig_n/seg_n reflect the state, index and shadow registers of the previous cycle (one-cycle latency).
  - SHOW: dig_n has a single 0 at the index position (ones = bit0); seg_n = decode(shadow digit at index).
  - GUARD: dig_n = 3'b111, seg_n = 7'b1111111.
- Decode (active-low {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10..15 = 0111111 (dash)
- Leading-zero blanking (blank_en = 1):
  - Hundreds is blanked if its shadow = 0.
  - Tens is blanked if shadow hundreds = 0 and shadow tens = 0.
  - Ones is never blanked.
  - A blanked digit drives seg_n = 7'b1111111 while its dig_n bit still goes low.
  - blank_en is sampled live, not shadowed.
- Full scan period = 3*(SCAN_DIV+GUARD_CYCLES) cycles.
- Boundaries:
  - load on the same edge as an index advance: the new value applies to the newly selected digit.
  - Reset during GUARD or mid-dwell: returns to SHOW/ones with counter 0; no partial glitch on dig_n beyond the asynchronous clear to 3'b111.

Decomposition:
- Package bcd_display_pkg holds:
  - the state enum {SHOW, GUARD}
  - digit index constants (DIG_ONES = 0, DIG_TENS = 1, DIG_HUNDREDS = 2)
  - segment constants SEG_BLANK = 7'b1111111 and SEG_DASH = 7'b0111111
  - the 16-entry decode table
- One combinational sub-module, seg7_decode (4-bit in, 7-bit active-low out), is instantiated once on the muxed digit.

Test Plan:
- Reset/timing: assert reset mid-run -> seg_n = 7F and dig_n = 111 immediately. With SCAN_DIV = 4 and GUARD_CYCLES = 2 after release:
  - dig_n low on bit0 for 4 cycles, then 2 cycles of 111
  - then bit1, then bit2
  - scan_tick period = 18 cycles
- Load {1,2,3}, blank_en = 0 -> ones phase seg_n = 0110000, tens phase 0100100, hundreds phase 1111001.
- Load {0,0,7}, blank_en = 1 -> ones phase shows 1111000. Tens and hundreds phases show seg_n = 1111111 with dig_n bit low. Setting blank_en = 0 shows 1000000 on both.
- Load {0,0xA,5}:
  - tens shows dash 0111111 and ones shows 0010010
  - with blank_en = 1, hundreds is blanked but tens is not (tens ≠ 0)
- Change the inputs without load -> display unchanged. Pulse load mid-dwell of the ones digit with {9,9,9} -> seg_n becomes 0010000 one cycle after the next cycle, with dig_n unchanged.
- GUARD_CYCLES = 0, SCAN_DIV = 1 -> dig_n rotates 110 -> 101 -> 011 every cycle, never 111, and scan_tick pulses every 3 cycles.
